output_port_arbiter: RTL and testbench
======================================

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 64, packet width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesting input buffers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  NUM_REQ  bit i high = requester i holds a packet for this output.
REQ-006 SHALL have port req_vc  input  NUM_REQ  virtual channel of requester i's packet (0 even, 1 odd); ignored when req[i]=0.
REQ-007 SHALL have port req_data  input  NUM_REQ*PACKET_WIDTH  packet of requester i in slice i.
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot grant; requester i drops its packet after the cycle in which gnt[i]=1.
REQ-009 SHALL have port polarity  input  1  link phase; only packets with req_vc == polarity are eligible this cycle.
REQ-010 SHALL have port out_so  output  1  send handshake: out_do holds a valid packet.
REQ-011 SHALL have port out_ro  input  1  downstream ready; transfer completes in a cycle with out_so=1 and out_ro=1.
REQ-012 SHALL have port out_do  output  PACKET_WIDTH  registered packet to the link.

Function
REQ-013 Eligible set E = {i : req[i]=1 and req_vc[i]=polarity}.
REQ-014 Output slot free = (out_so=0) or (out_so=1 and out_ro=1).
REQ-015 SHALL keep two round-robin pointers, ptr[0] (even VC) and ptr[1] (odd VC), each $clog2(NUM_REQ) bits.
REQ-016 When slot free and E non-empty: winner = first i in E searching from ptr[polarity] upward, wrapping NUM_REQ-1 -> 0.
REQ-017 gnt SHALL be combinational, same cycle as the decision; at most one bit high; all zero when slot not free, E empty, or reset=1.
REQ-018 On a grant: out_do <= req_data[winner], out_so <= 1, ptr[polarity] <= (winner+1) mod NUM_REQ; the other pointer is unchanged.
REQ-019 Latency: req eligible with slot free at cycle N -> out_so=1 and out_do valid at cycle N+1.
REQ-020 Stall: out_so=1 and out_ro=0 -> out_do and out_so held, no grant, pointers held.
REQ-021 Transfer with E non-empty in the same cycle: new packet loaded; out_so stays 1 (back-to-back, one packet per cycle).
REQ-022 Transfer with E empty: out_so <= 0; out_do holds its last value.
REQ-023 Requests whose req_vc != polarity SHALL be neither granted nor cause a pointer change; they wait for the matching phase.
REQ-024 A requester not granted SHALL see gnt[i]=0 and keep its packet; no packet is dropped or duplicated.

Reset
REQ-025 While reset=1 at posedge clk: out_so <= 0, out_do <= 0, ptr[0] <= 0, ptr[1] <= 0.
REQ-026 Reset mid-stall discards the held packet; the requester was already granted, so the packet is lost by design. Requesters not yet granted keep req and are arbitrated after reset deasserts.
REQ-027 gnt SHALL be all zero in every cycle with reset=1.

Structure
REQ-028 Shared package noc_pkg SHALL hold PACKET_WIDTH, NUM_REQ default, and VC encodings VC_EVEN=0, VC_ODD=1.
REQ-029 A single sub-module rr_arbiter (request vector + pointer in, one-hot grant out, combinational) SHALL be instantiated once; its pointer is muxed by polarity.

Verification
REQ-030 Single: reset, then req=0001, req_vc=0, polarity=0, out_ro=1, data0=64'hA5 -> gnt=0001 same cycle; next cycle out_so=1, out_do=64'hA5; ptr[0]=1.
REQ-031 Round-robin: req=1111, all vc=0, polarity=0, out_ro=1, each requester drops req after its grant -> grants 0001,0010,0100,1000 on consecutive cycles; out_so stays 1 for 4 cycles; ptr[0] wraps to 0.
REQ-032 Polarity: req=0011, req_vc=2'b10 for bits {1,0} (req1 odd, req0 even), polarity alternating 0,1 -> req0 granted on the even cycle and req1 on the odd cycle; ptr[0]=1, ptr[1]=2.
REQ-033 Stall: packet 64'h1 on link, out_ro=0 for 3 cycles, req=0010 pending -> out_do=64'h1 held, gnt=0 throughout; out_ro=1 -> gnt=0010 same cycle, out_do=req_data[1] next cycle.
REQ-034 Reset mid-stall: out_so=1, out_ro=0, assert reset 1 cycle -> out_so=0, out_do=0, pointers 0, gnt=0 during reset; pending req=0100 granted in the first cycle after reset deasserts.
REQ-035 Drain: single transfer, then req=0 -> out_so returns to 0 the cycle after the transfer; out_do unchanged.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC constants: default packet width, requester count and VC encodings.
// Purely declarative; no latency or backpressure of its own.
package noc_pkg;

  localparam int PACKET_WIDTH = 64;
  localparam int NUM_REQ      = 4;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr_i, wrapping; combinational, 0 cycles.
// No backpressure; the caller gates the grant when it cannot accept.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = noc_pkg::NUM_REQ
) (
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [ptr_width(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]            gnt_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output port arbiter: per-VC round-robin grant into a one-deep registered link slot; grant
// same cycle, packet on out_do one cycle later; out_ro low holds the slot and blocks all grants.
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int PACKET_WIDTH = noc_pkg::PACKET_WIDTH,
  parameter int NUM_REQ      = noc_pkg::NUM_REQ
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_vc,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              gnt,
  input  logic                            polarity,
  output logic                            out_so,
  input  logic                            out_ro,
  output logic [PACKET_WIDTH-1:0]         out_do
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0]         elig;
  logic [NUM_REQ-1:0]         arb_gnt;
  logic                       slot_free;
  logic [PTR_W-1:0]           ptr_inc;
  logic [1:0][PTR_W-1:0]      ptr_q, ptr_d;
  logic                       out_so_q, out_so_d;
  logic [PACKET_WIDTH-1:0]    out_do_q, out_do_d;

  // Only packets on the VC matching the current link phase compete.
  assign elig      = req & ~(req_vc ^ {NUM_REQ{polarity}});
  assign slot_free = ~out_so_q | out_ro;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (elig),
    .ptr_i (ptr_q[polarity]),
    .gnt_o (arb_gnt)
  );

  assign gnt = (slot_free && !reset) ? arb_gnt : '0;

  always_comb begin
    out_do_d = out_do_q;
    out_so_d = out_so_q;
    ptr_d    = ptr_q;
    ptr_inc  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        out_do_d = req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
        ptr_inc  = PTR_W'((i + 1) % NUM_REQ);
      end
    end
    if (|gnt) begin
      out_so_d        = 1'b1;
      ptr_d[polarity] = ptr_inc;
    end else if (slot_free) begin
      out_so_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_so_q <= 1'b0;
      out_do_q <= '0;
      ptr_q    <= '0;
    end else begin
      out_so_q <= out_so_d;
      out_do_q <= out_do_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_so = out_so_q;
  assign out_do = out_do_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed cycles check grants/state inline, while a monitor
// pops expected link packets from a scoreboard queue on every out_so && out_ro transfer.
module tb_output_port_arbiter;

  localparam int PW = 64;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req, req_vc, gnt;
  logic [NR*PW-1:0] req_data;
  logic             polarity, out_so, out_ro;
  logic [PW-1:0]    out_do;

  logic [PW-1:0]    exp_q[$];
  int               n_cmp  = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  output_port_arbiter #(.PACKET_WIDTH(PW), .NUM_REQ(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_vc   (req_vc),
    .req_data (req_data),
    .gnt      (gnt),
    .polarity (polarity),
    .out_so   (out_so),
    .out_ro   (out_ro),
    .out_do   (out_do)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_data(input int i, input logic [PW-1:0] v);
    req_data[i*PW +: PW] = v;
  endtask

  // Scoreboard monitor: every completed link transfer must match the oldest expected packet.
  initial begin
    logic [PW-1:0] e_v;
    forever begin
      @(negedge clk);
      if (!reset && out_so === 1'b1 && out_ro === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL xfer_unexpected: got %h, none expected", out_do);
        end else begin
          e_v = exp_q.pop_front();
          chk("xfer_data", out_do, e_v);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req = '0; req_vc = '0; req_data = '0; polarity = 1'b0; out_ro = 1'b1;
    set_data(0, 64'hA5);
    tick();
    req = 4'b0001;
    @(negedge clk);
    chk("rst_gnt",  gnt, 0);
    chk("rst_so",   out_so, 0);
    chk("rst_do",   out_do, 0);
    chk("rst_ptr0", dut.ptr_q[0], 0);
    chk("rst_ptr1", dut.ptr_q[1], 0);
    tick();
    reset = 1'b0;

    // Single request, then drain
    exp_q.push_back(64'hA5);
    @(negedge clk); chk("single_gnt", gnt, 4'b0001);
    tick(); req = '0;
    @(negedge clk);
    chk("single_so", out_so, 1); chk("single_do", out_do, 64'hA5);
    chk("single_ptr0", dut.ptr_q[0], 1); chk("single_gnt_idle", gnt, 0);
    tick();
    @(negedge clk); chk("drain_so", out_so, 0); chk("drain_do", out_do, 64'hA5);
    tick(); pulse_reset();

    // Round-robin over all four, back-to-back
    for (int i = 0; i < NR; i++) set_data(i, 64'h100 + 64'(i));
    req = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      exp_q.push_back(64'h100 + 64'(k));
      @(negedge clk);
      chk("rr_gnt", gnt, 64'd1 << k);
      if (k > 0) chk("rr_so", out_so, 1);
      tick(); req[k] = 1'b0;
    end
    @(negedge clk);
    chk("rr_so_last", out_so, 1); chk("rr_ptr0_wrap", dut.ptr_q[0], 0); chk("rr_gnt_idle", gnt, 0);
    tick(); pulse_reset();

    // Polarity: req0 even, req1 odd
    set_data(0, 64'hE0); set_data(1, 64'hD1);
    req = 4'b0011; req_vc = 4'b0010; polarity = 1'b0;
    exp_q.push_back(64'hE0);
    @(negedge clk); chk("pol_even_gnt", gnt, 4'b0001);
    tick(); req = 4'b0010; polarity = 1'b1;
    exp_q.push_back(64'hD1);
    @(negedge clk); chk("pol_odd_gnt", gnt, 4'b0010);
    tick(); req = '0;
    @(negedge clk); chk("pol_ptr0", dut.ptr_q[0], 1); chk("pol_ptr1", dut.ptr_q[1], 2);
    tick();
    req = 4'b0001; req_vc = '0; polarity = 1'b1; set_data(0, 64'hE2);
    @(negedge clk); chk("pol_wait_gnt", gnt, 0); chk("pol_wait_ptr1", dut.ptr_q[1], 2);
    tick(); polarity = 1'b0;
    exp_q.push_back(64'hE2);
    @(negedge clk); chk("pol_match_gnt", gnt, 4'b0001);
    tick(); req = '0;
    @(negedge clk); chk("pol_match_ptr0", dut.ptr_q[0], 1);
    tick(); pulse_reset();

    // Stall with a pending request
    set_data(0, 64'h1); set_data(1, 64'h22);
    req = 4'b0001; out_ro = 1'b0;
    exp_q.push_back(64'h1);
    @(negedge clk); chk("stall_load_gnt", gnt, 4'b0001);
    tick(); req = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      chk("stall_gnt", gnt, 0); chk("stall_so", out_so, 1);
      chk("stall_do", out_do, 64'h1); chk("stall_ptr0", dut.ptr_q[0], 1);
      tick();
    end
    out_ro = 1'b1;
    exp_q.push_back(64'h22);
    @(negedge clk); chk("stall_release_gnt", gnt, 4'b0010);
    tick(); req = '0;
    @(negedge clk); chk("stall_next_do", out_do, 64'h22); chk("stall_ptr0_adv", dut.ptr_q[0], 2);
    tick(); pulse_reset();

    // Reset during a stall discards the held packet
    set_data(0, 64'h77); set_data(2, 64'h33);
    req = 4'b0001; out_ro = 1'b0;
    exp_q.push_back(64'h77);
    @(negedge clk); chk("ms_load_gnt", gnt, 4'b0001);
    tick(); req = 4'b0100;
    @(negedge clk); chk("ms_stall_gnt", gnt, 0);
    tick(); reset = 1'b1;
    @(negedge clk); chk("ms_rst_gnt", gnt, 0);
    exp_q.delete();
    tick(); reset = 1'b0;
    exp_q.push_back(64'h33);
    @(negedge clk);
    chk("ms_so", out_so, 0); chk("ms_do", out_do, 0);
    chk("ms_ptr0", dut.ptr_q[0], 0); chk("ms_ptr1", dut.ptr_q[1], 0);
    chk("ms_gnt_after", gnt, 4'b0100);
    tick(); req = '0; out_ro = 1'b1;
    @(negedge clk); chk("ms_after_so", out_so, 1); chk("ms_after_do", out_do, 64'h33);
    tick(); tick();
    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
